// File: rtl/riscv_hazard_unit.sv
// Hazard/forwarding controller: tracks rd across DEPTH post-decode stages (1 = EX .. DEPTH = WB).
// Latency: selects, stall and flush are combinational from tracked state plus ID inputs; tracking shifts every clock.
// Backpressure: stall holds PC and IF/ID only and never freezes tracked stages; HAZARD_STATS_EN adds saturating counters.
module riscv_hazard_unit #(
  parameter int NREGS      = 32,
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 2,
  localparam int RA_W      = $clog2(NREGS),
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic            id_reg_write,
  input  logic            id_is_load,
  input  logic            ex_redirect,
  output logic            stall,
  output logic            flush_ifid,
  output logic            issue,
  output logic [SW-1:0]   fwd_sel_rs1,
  output logic [SW-1:0]   fwd_sel_rs2,
  output logic [SW-1:0]   in_flight
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]     stall_count,
  output logic [31:0]     flush_count
`endif
);

  logic [DEPTH:1]           st_vld;
  logic [DEPTH:1]           st_wr;
  logic [DEPTH:1]           st_ld;
  logic [DEPTH:1][RA_W-1:0] st_rd;

  logic [1:0][RA_W-1:0] rs;
  logic [1:0]           use_rs;
  logic [1:0][SW-1:0]   sel;
  logic [1:0]           load_use;

  assign rs     = {id_rs2, id_rs1};
  assign use_rs = {id_use_rs2, id_use_rs1};

  // Scan oldest to youngest so the youngest matching stage is the one that sticks.
  always_comb begin
    sel      = '0;
    load_use = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (use_rs[s] && (rs[s] != '0) && st_vld[k] && st_wr[k] && (st_rd[k] == rs[s])) begin
          sel[s]      = SW'(k);
          load_use[s] = st_ld[k] && (k < LOAD_READY);
        end
      end
    end
  end

  assign fwd_sel_rs1 = sel[0];
  assign fwd_sel_rs2 = sel[1];
  assign stall       = id_valid & (|load_use) & ~ex_redirect;
  assign issue       = id_valid & ~stall & ~ex_redirect;
  assign flush_ifid  = ex_redirect;
  assign in_flight   = SW'($countones(st_vld));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_vld <= '0;
      st_wr  <= '0;
      st_ld  <= '0;
      st_rd  <= '0;
    end else begin
      st_vld <= {st_vld[DEPTH-1:1], issue};
      st_wr  <= {st_wr[DEPTH-1:1], issue & id_reg_write};
      st_ld  <= {st_ld[DEPTH-1:1], issue & id_is_load};
      st_rd  <= {st_rd[DEPTH-1:1], issue ? id_rd : {RA_W{1'b0}}};
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall && (stall_count != 32'hFFFF_FFFF)) stall_count <= stall_count + 32'd1;
      if (flush_ifid && (flush_count != 32'hFFFF_FFFF)) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Bench for riscv_hazard_unit: DEPTH 3/LR 2 and DEPTH 5/LR 4 instances against a queue-based pipeline model.
module tb_riscv_hazard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic id_reg_write = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;

  logic       stall3, flush3, issue3;
  logic [1:0] sel1_3, sel2_3, inf3;
  logic       stall5, flush5, issue5;
  logic [2:0] sel1_5, sel2_5, inf5;
`ifdef HAZARD_STATS_EN
  logic [31:0] sc3, fc3, sc5, fc5;
`endif

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {logic v; logic [4:0] rd; logic wr; logic ld;} ent_t;
  typedef struct {int s1; int s2; logic st; logic fl; logic is; int inf;} exp_t;

  ent_t q3[$];
  ent_t q5[$];
  exp_t e3, e5;
  int cs3 = 0, cf3 = 0, cs5 = 0, cf5 = 0;
  int base_cs3;

  always #5 clk = ~clk;

  riscv_hazard_unit #(.NREGS(32), .DEPTH(3), .LOAD_READY(2)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall(stall3), .flush_ifid(flush3), .issue(issue3),
    .fwd_sel_rs1(sel1_3), .fwd_sel_rs2(sel2_3), .in_flight(inf3)
`ifdef HAZARD_STATS_EN
    , .stall_count(sc3), .flush_count(fc3)
`endif
  );

  riscv_hazard_unit #(.NREGS(32), .DEPTH(5), .LOAD_READY(4)) dut5 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_redirect(ex_redirect),
    .stall(stall5), .flush_ifid(flush5), .issue(issue5),
    .fwd_sel_rs1(sel1_5), .fwd_sel_rs2(sel2_5), .in_flight(inf5)
`ifdef HAZARD_STATS_EN
    , .stall_count(sc5), .flush_count(fc5)
`endif
  );

  // Reference: queue index 0 is the youngest in-flight slot (stage 1).
  function automatic int find(input ent_t q[$], input logic use_s, input logic [4:0] rs);
    int hit = 0;
    if (use_s && rs != 5'd0)
      for (int i = 0; i < q.size(); i++)
        if (hit == 0 && q[i].v && q[i].wr && q[i].rd == rs) hit = i + 1;
    return hit;
  endfunction

  function automatic exp_t model(input ent_t q[$], input int lr);
    exp_t e;
    logic lu = 1'b0;
    e.s1 = find(q, id_use_rs1, id_rs1);
    e.s2 = find(q, id_use_rs2, id_rs2);
    if (e.s1 != 0 && q[e.s1-1].ld && e.s1 < lr) lu = 1'b1;
    if (e.s2 != 0 && q[e.s2-1].ld && e.s2 < lr) lu = 1'b1;
    e.fl  = ex_redirect;
    e.st  = id_valid && lu && !ex_redirect;
    e.is  = id_valid && !e.st && !ex_redirect;
    e.inf = 0;
    foreach (q[i]) if (q[i].v) e.inf++;
    return e;
  endfunction

  task automatic clear_models();
    q3.delete();
    q5.delete();
    repeat (3) q3.push_back(ent_t'(0));
    repeat (5) q5.push_back(ent_t'(0));
    cs3 = 0; cf3 = 0; cs5 = 0; cf5 = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic rdr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use_rs1 = u1; id_use_rs2 = u2;
    id_rd = rd; id_reg_write = wr; id_is_load = ld; ex_redirect = rdr;
  endtask

  task automatic eval(input string tag);
    #2;
    e3 = model(q3, 2);
    e5 = model(q5, 4);
    check({tag, "/d3.sel1"},  32'(sel1_3), 32'(e3.s1));
    check({tag, "/d3.sel2"},  32'(sel2_3), 32'(e3.s2));
    check({tag, "/d3.stall"}, 32'(stall3), 32'(e3.st));
    check({tag, "/d3.flush"}, 32'(flush3), 32'(e3.fl));
    check({tag, "/d3.issue"}, 32'(issue3), 32'(e3.is));
    check({tag, "/d3.inf"},   32'(inf3),   32'(e3.inf));
    check({tag, "/d5.sel1"},  32'(sel1_5), 32'(e5.s1));
    check({tag, "/d5.sel2"},  32'(sel2_5), 32'(e5.s2));
    check({tag, "/d5.stall"}, 32'(stall5), 32'(e5.st));
    check({tag, "/d5.flush"}, 32'(flush5), 32'(e5.fl));
    check({tag, "/d5.issue"}, 32'(issue5), 32'(e5.is));
    check({tag, "/d5.inf"},   32'(inf5),   32'(e5.inf));
`ifdef HAZARD_STATS_EN
    check({tag, "/d3.scnt"}, sc3, 32'(cs3));
    check({tag, "/d3.fcnt"}, fc3, 32'(cf3));
    check({tag, "/d5.scnt"}, sc5, 32'(cs5));
    check({tag, "/d5.fcnt"}, fc5, 32'(cf5));
`endif
  endtask

  task automatic tick();
    ent_t n;
    @(posedge clk);
    if (reset) begin
      clear_models();
    end else begin
      n = {1'b1, id_rd, id_reg_write, id_is_load};
      q3.push_front(e3.is ? n : ent_t'(0)); void'(q3.pop_back());
      q5.push_front(e5.is ? n : ent_t'(0)); void'(q5.pop_back());
      if (e3.st) cs3++;
      if (e3.fl) cf3++;
      if (e5.st) cs5++;
      if (e5.fl) cf5++;
    end
    @(negedge clk);
  endtask

  initial begin
    clear_models();
    @(negedge clk);
    eval("rst");
    check("rst.inf3", 32'(inf3), 0);
    check("rst.stall3", 32'(stall3), 0);
    check("rst.issue3", 32'(issue3), 0);
    tick();
    reset = 1'b0;

    // Back-to-back ALU dependency: stage 1 then stage 2 forwarding.
    drive(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0); eval("t2.add"); tick();
    drive(1, 5'd5, 5'd5, 1, 1, 5'd6, 0, 0, 0); eval("t2.rd1");
    check("t2.sel1", 32'(sel1_3), 1);
    check("t2.sel2", 32'(sel2_3), 1);
    check("t2.stall", 32'(stall3), 0);
    tick();
    eval("t2.rd2");
    check("t2.sel1_s2", 32'(sel1_3), 2);
    tick();

    // Load-use: one stall on DEPTH 3, three on DEPTH 5 / LOAD_READY 4.
    drive(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0); eval("t3.lw"); tick();
    drive(1, 5'd1, 5'd7, 0, 1, 5'd8, 0, 0, 0);
    base_cs3 = cs3;
    for (int c = 0; c < 4; c++) begin
      eval($sformatf("t3.c%0d", c));
      if (c == 0) begin
        check("t3.stall3_c0", 32'(stall3), 1);
        check("t3.issue3_c0", 32'(issue3), 0);
      end
      if (c == 1) begin
        check("t3.stall3_c1", 32'(stall3), 0);
        check("t3.sel2_3_c1", 32'(sel2_3), 2);
        check("t3.issue3_c1", 32'(issue3), 1);
`ifdef HAZARD_STATS_EN
        check("t3.scnt_delta", sc3 - 32'(base_cs3), 1);
`endif
      end
      check($sformatf("t6.stall5_c%0d", c), 32'(stall5), (c < 3) ? 1 : 0);
      if (c == 3) check("t6.sel2_5", 32'(sel2_5), 4);
      check($sformatf("t6.inf5_le5_c%0d", c), 32'(inf5 <= 3'd5), 1);
      tick();
    end

    // Youngest writer wins; x0 never forwards.
    drive(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); eval("t4.w3a"); tick();
    drive(1, 5'd0, 5'd0, 0, 0, 5'd4, 1, 0, 0); eval("t4.w4"); tick();
    drive(1, 5'd0, 5'd0, 0, 0, 5'd3, 1, 0, 0); eval("t4.w3b"); tick();
    drive(1, 5'd3, 5'd3, 1, 1, 5'd0, 0, 0, 0); eval("t4.rd3");
    check("t4.sel1_young", 32'(sel1_3), 1);
    check("t4.sel2_young", 32'(sel2_3), 1);
    tick();
    drive(1, 5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 0); eval("t4.w0"); tick();
    drive(1, 5'd0, 5'd0, 1, 0, 5'd0, 0, 0, 0); eval("t4.rd0");
    check("t4.sel1_x0", 32'(sel1_3), 0);
    tick();

    // Redirect beats a load-use stall.
    drive(1, 5'd0, 5'd0, 0, 0, 5'd7, 1, 1, 0); eval("t5.lw"); tick();
    drive(1, 5'd7, 5'd0, 1, 0, 5'd9, 1, 0, 1); eval("t5.redir");
    check("t5.stall", 32'(stall3), 0);
    check("t5.flush", 32'(flush3), 1);
    check("t5.issue", 32'(issue3), 0);
    check("t5.inf_pre", 32'(inf3), 3);
    tick();
    drive(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0); eval("t5.after");
    check("t5.inf_post", 32'(inf3), 2);
    tick();

    // Asynchronous reset with a full pipeline.
    drive(1, 5'd0, 5'd0, 0, 0, 5'd5, 1, 0, 0); eval("t1.w5"); tick();
    drive(1, 5'd0, 5'd0, 0, 0, 5'd6, 1, 0, 0); eval("t1.w6"); tick();
    drive(1, 5'd0, 5'd0, 0, 0, 5'd8, 1, 0, 0); eval("t1.w8"); tick();
    drive(1, 5'd5, 5'd0, 1, 0, 5'd0, 0, 0, 0); eval("t1.pre");
    check("t1.inf_full", 32'(inf3), 3);
    check("t1.sel_pre", 32'(sel1_3), 3);
    reset = 1'b1;
    #1;
    check("t1.inf3_async", 32'(inf3), 0);
    check("t1.sel3_async", 32'(sel1_3), 0);
    check("t1.inf5_async", 32'(inf5), 0);
    check("t1.sel5_async", 32'(sel1_5), 0);
    tick();
    reset = 1'b0;
    eval("t1.post");
    check("t1.sel_post", 32'(sel1_3), 0);
    tick();

    // Random traffic with small register range to force frequent hazards.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      eval("rnd");
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #1;
        check("rnd.rst_inf3", 32'(inf3), 0);
        check("rnd.rst_inf5", 32'(inf5), 0);
        tick();
        reset = 1'b0;
      end else begin
        tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
